// File: rtl/hdmi_packet_pkg.sv
// Shared constants, types and the single-bit BCH step used by the HDMI data-island serializer.
package hdmi_packet_pkg;

    localparam logic [7:0] ECC_POLY_DEFAULT = 8'b1000_0011;
    localparam int PACKET_PIXELS = 32;
    localparam int HEADER_BITS   = 24;
    localparam int SUB_BITS      = 56;

    typedef logic [HEADER_BITS-1:0] header_t;
    typedef logic [SUB_BITS-1:0]    subpacket_t;

    // Reflected LFSR step: shift toward bit 0, fold the generator in when the feedback bit is set.
    function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic b,
                                            input logic [7:0] poly);
        return {1'b0, ecc[7:1]} ^ ({8{ecc[0] ^ b}} & poly);
    endfunction

endpackage

// File: rtl/packet_serializer_bch_ecc8.sv
// Serial 8-bit BCH parity engine: BITS_PER_CLK steps per clock, seeded from zero on start, frozen on hold.
module bch_ecc8
    import hdmi_packet_pkg::*;
#(
    parameter int         BITS_PER_CLK = 1,
    parameter logic [7:0] ECC_POLY     = ECC_POLY_DEFAULT
) (
    input  logic                    clk_pixel,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    hold,
    input  logic [BITS_PER_CLK-1:0] bits,
    output logic [7:0]              ecc
);

    logic [7:0] ecc_next;

    // NOTE: every path assigns ecc_next before any branch reads it, so no latch is inferred.
    always_comb begin
        ecc_next = start ? 8'd0 : ecc;
        for (int i = 0; i < BITS_PER_CLK; i++) begin
            ecc_next = bch_step(ecc_next, bits[i], ECC_POLY);
        end
        if (hold) begin
            ecc_next = ecc;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            ecc <= 8'd0;
        end else begin
            ecc <= ecc_next;
        end
    end

endmodule

// File: rtl/packet_serializer.sv
// HDMI data-island packet serializer: header + 4 subpackets + BCH parity, one 9-bit word per pixel.
// Define PACKET_SNAPSHOT_EN to latch packet contents at pixel 0 so upstream may change mid-packet.
module packet_serializer
    import hdmi_packet_pkg::*;
#(
    parameter logic [7:0] ECC_POLY = ECC_POLY_DEFAULT,
    parameter int         NUM_SUB  = 4
) (
    input  logic             clk_pixel,
    input  logic             reset_n,
    input  logic             data_island_period,
    input  logic [23:0]      header,
    input  logic [3:0][55:0] sub,
    output logic             packet_enable,
    output logic [4:0]       packet_pixel_counter,
    output logic [8:0]       packet_data
);

    logic [4:0]       cnt;
    logic [23:0]      hdr_use;
    logic [3:0][55:0] sub_use;
    logic [31:0]      hdr_pad;
    logic [5:0]       even_idx;
    logic [5:0]       odd_idx;
    logic [7:0]       eh;
    logic             hb;
    logic [3:0]       ev;
    logic [3:0]       od;
    logic             seed;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 5'd0;
        end else if (!data_island_period) begin
            cnt <= 5'd0;
        end else begin
            cnt <= cnt + 5'd1;
        end
    end

    assign packet_pixel_counter = cnt;
    assign packet_enable        = data_island_period && (cnt == 5'd31);
    assign seed                 = (cnt == 5'd0);

`ifdef PACKET_SNAPSHOT_EN
    logic [23:0]      hdr_shadow;
    logic [3:0][55:0] sub_shadow;

    // NOTE: the shadow registers are plain flops, not a RAM, so they take the reset like any other state.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            hdr_shadow <= '0;
            sub_shadow <= '0;
        end else if (data_island_period && seed) begin
            hdr_shadow <= header;
            sub_shadow <= sub;
        end
    end

    assign hdr_use = seed ? header : hdr_shadow;
    assign sub_use = seed ? sub    : sub_shadow;
`else
    assign hdr_use = header;
    assign sub_use = sub;
`endif

    // Zero padding keeps the pixel-indexed selects in range for the parity pixels.
    assign hdr_pad  = {8'd0, hdr_use};
    assign even_idx = {cnt, 1'b0};
    assign odd_idx  = {cnt, 1'b1};

    bch_ecc8 #(.BITS_PER_CLK(1), .ECC_POLY(ECC_POLY)) u_ecc_hdr (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .start     (seed),
        .hold      (cnt >= 5'd24),
        .bits      (hdr_pad[cnt]),
        .ecc       (eh)
    );

    assign hb = (cnt < 5'd24) ? hdr_pad[cnt] : eh[cnt[2:0]];

    for (genvar i = 0; i < NUM_SUB; i++) begin : g_sub
        logic [63:0] pad;
        logic [7:0]  es;

        assign pad = {8'd0, sub_use[i]};

        bch_ecc8 #(.BITS_PER_CLK(2), .ECC_POLY(ECC_POLY)) u_ecc_sub (
            .clk_pixel (clk_pixel),
            .reset_n   (reset_n),
            .start     (seed),
            .hold      (cnt >= 5'd28),
            .bits      ({pad[odd_idx], pad[even_idx]}),
            .ecc       (es)
        );

        assign ev[i] = (cnt < 5'd28) ? pad[even_idx] : es[{cnt[1:0], 1'b0}];
        assign od[i] = (cnt < 5'd28) ? pad[odd_idx]  : es[{cnt[1:0], 1'b1}];
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            packet_data <= 9'd0;
        end else if (!data_island_period) begin
            packet_data <= 9'd0;
        end else begin
            packet_data <= {od, ev, hb};
        end
    end

    always_ff @(posedge clk_pixel) begin
        assert (NUM_SUB == 4);
    end

endmodule

// File: tb/tb_packet_serializer.sv
// Directed, table-driven bench for packet_serializer with hand-computed BCH parity words.
`timescale 1ns/1ps
module tb_packet_serializer;
    import hdmi_packet_pkg::*;

    typedef logic [3:0][55:0] subs_t;
    typedef struct {
        logic [23:0] hdr;
        subs_t       sub;
        int          pix;
        logic [8:0]  exp;
    } vec_t;

    logic        clk_pixel = 1'b0;
    logic        reset_n = 1'b0;
    logic        data_island_period = 1'b0;
    logic [23:0] header = '0;
    subs_t       sub = '0;
    logic        packet_enable;
    logic [4:0]  packet_pixel_counter;
    logic [8:0]  packet_data;

    int tests = 0;
    int fails = 0;
    logic [8:0] words [64];
    logic       pes [64];
    logic [4:0] cnts [64];
    vec_t       vecs [$];

    packet_serializer dut (
        .clk_pixel            (clk_pixel),
        .reset_n              (reset_n),
        .data_island_period   (data_island_period),
        .header               (header),
        .sub                  (sub),
        .packet_enable        (packet_enable),
        .packet_pixel_counter (packet_pixel_counter),
        .packet_data          (packet_data)
    );

    always #5 clk_pixel = ~clk_pixel;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic subs_t one_sub(input int idx, input logic [55:0] v);
        subs_t s;
        s      = '0;
        s[idx] = v;
        return s;
    endfunction

    function automatic logic [7:0] hb_byte(input int base);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = words[base + j][0];
        return b;
    endfunction

    task automatic add(input logic [23:0] h, input subs_t s, input int p, input logic [8:0] e);
        vec_t v;
        v.hdr = h;
        v.sub = s;
        v.pix = p;
        v.exp = e;
        vecs.push_back(v);
    endtask

    // Runs n pixels from cnt 0; after the sample where cnt becomes chg_at, switches to h2/s2.
    task automatic run_packet(input logic [23:0] h, input subs_t s, input int n,
                              input int chg_at, input logic [23:0] h2, input subs_t s2);
        @(negedge clk_pixel);
        header = h;
        sub = s;
        data_island_period = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk_pixel);
            words[k] = packet_data;
            pes[k]   = packet_enable;
            cnts[k]  = packet_pixel_counter;
            if (k + 1 == chg_at) begin
                header = h2;
                sub = s2;
            end
        end
        data_island_period = 1'b0;
    endtask

    initial begin
        subs_t mix;
        int    pe_count;

        #12;
        check("reset packet_data", packet_data, 9'd0);
        check("reset packet_enable", packet_enable, 1'b0);
        check("reset counter", packet_pixel_counter, 5'd0);
        @(negedge clk_pixel);
        reset_n = 1'b1;

        mix = '0;
        mix[0] = 56'd1;
        mix[3] = 56'd2;
        add(24'h800000, '0, 0,  9'h000);
        add(24'h800000, '0, 23, 9'h001);
        add(24'h800000, '0, 24, 9'h001);
        add(24'h800000, '0, 25, 9'h001);
        add(24'h800000, '0, 26, 9'h000);
        add(24'h800000, '0, 30, 9'h000);
        add(24'h800000, '0, 31, 9'h001);
        add(24'h400000, '0, 22, 9'h001);
        add(24'h400000, '0, 24, 9'h000);
        add(24'h400000, '0, 25, 9'h001);
        add(24'h400000, '0, 30, 9'h001);
        add(24'h400000, '0, 31, 9'h001);
        add(24'h200000, '0, 21, 9'h001);
        add(24'h200000, '0, 24, 9'h001);
        add(24'h200000, '0, 25, 9'h000);
        add(24'h200000, '0, 29, 9'h001);
        add(24'h200000, '0, 30, 9'h001);
        add(24'h000000, one_sub(2, 56'h80_0000_0000_0000), 27, 9'h080);
        add(24'h000000, one_sub(2, 56'h80_0000_0000_0000), 28, 9'h088);
        add(24'h000000, one_sub(2, 56'h80_0000_0000_0000), 29, 9'h000);
        add(24'h000000, one_sub(2, 56'h80_0000_0000_0000), 31, 9'h080);
        add(24'h000000, one_sub(1, 56'h40_0000_0000_0000), 27, 9'h004);
        add(24'h000000, one_sub(1, 56'h40_0000_0000_0000), 28, 9'h040);
        add(24'h000000, one_sub(1, 56'h40_0000_0000_0000), 31, 9'h044);
        add(24'h000001, mix, 0, 9'h103);
        add(24'h000001, mix, 1, 9'h000);

        foreach (vecs[i]) begin
            run_packet(vecs[i].hdr, vecs[i].sub, 32, -1, vecs[i].hdr, vecs[i].sub);
            check($sformatf("vec%0d pix%0d", i, vecs[i].pix), words[vecs[i].pix], vecs[i].exp);
        end

        // Back-to-back packets; the picker swaps the header as the second packet starts.
        run_packet(24'h800000, '0, 64, 32, 24'h400000, '0);
        check("b2b packet1 header ecc", hb_byte(24), 8'h83);
        check("b2b packet2 header ecc", hb_byte(56), 8'hC2);
        pe_count = 0;
        for (int k = 0; k < 64; k++) if (pes[k]) pe_count++;
        check("b2b enable count", pe_count, 2);
        check("b2b enable at cnt31 pkt1", pes[30], 1'b1);
        check("b2b enable at cnt31 pkt2", pes[62], 1'b1);
        check("b2b counter mid pkt1", cnts[9], 5'd10);
        check("b2b counter wrap", cnts[31], 5'd0);
        check("b2b counter mid pkt2", cnts[40], 5'd9);

        // Island dropped at cnt 10, then a clean packet.
        @(negedge clk_pixel);
        header = 24'hFFFFFF;
        sub = '0;
        data_island_period = 1'b1;
        for (int k = 0; k < 10; k++) @(negedge clk_pixel);
        check("drop before counter", packet_pixel_counter, 5'd10);
        check("drop before data", packet_data, 9'h001);
        data_island_period = 1'b0;
        @(negedge clk_pixel);
        check("drop counter", packet_pixel_counter, 5'd0);
        check("drop data", packet_data, 9'd0);
        check("drop enable", packet_enable, 1'b0);
        run_packet(24'h800000, '0, 32, -1, 24'h800000, '0);
        check("after drop header ecc", hb_byte(24), 8'h83);
        check("after drop pix23", words[23], 9'h001);

        // Asynchronous reset in the middle of a packet.
        @(negedge clk_pixel);
        header = 24'hFFFFFF;
        data_island_period = 1'b1;
        for (int k = 0; k < 6; k++) @(negedge clk_pixel);
        check("pre-reset counter", packet_pixel_counter, 5'd6);
        check("pre-reset data", packet_data, 9'h001);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset data", packet_data, 9'd0);
        check("async reset counter", packet_pixel_counter, 5'd0);
        check("async reset enable", packet_enable, 1'b0);
        data_island_period = 1'b0;
        @(negedge clk_pixel);
        reset_n = 1'b1;

        // Subpacket 0 changes at cnt 5.
        run_packet(24'h000000, '0, 32, 5, 24'h000000, one_sub(0, 56'hFF_FFFF_FFFF_FFFF));
        check("midchange pix3", words[3], 9'h000);
`ifdef PACKET_SNAPSHOT_EN
        check("midchange pix5", words[5], 9'h000);
        check("midchange pix10", words[10], 9'h000);
`else
        check("midchange pix5", words[5], 9'h022);
        check("midchange pix10", words[10], 9'h022);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
